// File: rtl/mem_share_arbiter_pkg.sv
// Shared types for the main-memory port arbiter: the write-side bundle that is muxed
// between the pipeline and the secondary requester.
package mem_share_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef struct packed {
    logic              write;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
    logic              wgrubby;
  } mem_wr_t;

endpackage

// File: rtl/mem_share_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] LimitVal = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != LimitVal)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count    = count_q;
  assign at_limit = (count_q == LimitVal);

endmodule

// File: rtl/mem_share_arbiter.sv
// Shares the main-memory port between the never-stalling pipeline (absolute priority)
// and one secondary requester served only in cycles the pipeline leaves memory idle.
//
// state | meaning
// IDLE  | no secondary request outstanding
// WAIT  | request pending, blocked by the pipeline last cycle
// RESP  | read was granted last cycle; memory data is returning now
module mem_share_arbiter
  import mem_share_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_WIDTH = 8,
  parameter int STARVE_LIMIT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_valid,
  input  logic                  cpu_write,
  input  logic [MASK_W-1:0]     cpu_wmask,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic                  cpu_wgrubby,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_rgrubby,
  input  logic                  sec_req,
  input  logic                  sec_write,
  input  logic [MASK_W-1:0]     sec_wmask,
  input  logic [DATA_W-1:0]     sec_wdata,
  input  logic                  sec_wgrubby,
  input  logic [ADDR_WIDTH-1:0] sec_addr,
  output logic                  sec_ack,
  output logic                  sec_rvalid,
  output logic [DATA_W-1:0]     sec_rdata,
  output logic                  sec_rgrubby,
  output logic                  sec_starved,
  output logic                  mem_write,
  output logic [MASK_W-1:0]     mem_wmask,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_wgrubby,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rgrubby
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [STARVE_WIDTH-1:0] StarveMax = STARVE_WIDTH'(STARVE_LIMIT);

  state_e                  state_q;
  logic                    grant;
  logic                    starve_at_limit;
  logic [STARVE_WIDTH-1:0] starve_cnt;
  mem_wr_t                 cpu_wr;
  mem_wr_t                 sec_wr;
  mem_wr_t                 mux_wr;

  assign grant   = ~rst & sec_req & ~cpu_valid;
  assign sec_ack = grant;

  // Pipeline write only counts when it actually owns the port this cycle.
  assign cpu_wr = '{write: cpu_valid & cpu_write, wmask: cpu_wmask,
                    wdata: cpu_wdata, wgrubby: cpu_wgrubby};
  assign sec_wr = '{write: sec_write, wmask: sec_wmask,
                    wdata: sec_wdata, wgrubby: sec_wgrubby};
  assign mux_wr = grant ? sec_wr : cpu_wr;

  assign mem_write   = ~rst & mux_wr.write;
  assign mem_wmask   = mux_wr.wmask;
  assign mem_wdata   = mux_wr.wdata;
  assign mem_wgrubby = mux_wr.wgrubby;
  assign mem_addr    = grant ? sec_addr : cpu_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (grant && !sec_write) begin
      state_q <= ST_RESP;
    end else if (sec_req && !grant) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= ST_IDLE;
    end
  end

  // Reset must squash a response already in flight, so it gates the registered flag.
  assign sec_rvalid  = (state_q == ST_RESP) & ~rst;
  assign sec_rdata   = mem_rdata;
  assign sec_rgrubby = mem_rgrubby;
  assign cpu_rdata   = mem_rdata;
  assign cpu_rgrubby = mem_rgrubby;

  sat_counter #(
    .WIDTH (STARVE_WIDTH),
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .clr      (rst | grant | ~sec_req),
    .inc      (sec_req & ~grant & ~starve_at_limit),
    .count    (starve_cnt),
    .at_limit (starve_at_limit)
  );

  assign sec_starved = (starve_cnt == StarveMax);

endmodule
